// File: rtl/cache_perf_counter_unit.sv
// Cache hit/miss/read/write event counters with a four-phase snapshot port.
// Counters live internally; snapshots are captured only on the S_IDLE -> S_ACK edge.
module cache_perf_counter_unit #(
  parameter int unsigned XLEN     = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            count_en,
  input  logic            clear,
  input  logic            req_valid,
  input  logic            req_ready,
  input  logic            req_we,
  input  logic            resp_valid,
  input  logic            resp_hit,
  input  logic            snap_req,
  output logic            snap_ack,
  output logic [XLEN-1:0] hit_value,
  output logic [XLEN-1:0] miss_value,
  output logic [XLEN-1:0] read_value,
  output logic [XLEN-1:0] write_value,
  output logic [3:0]      overflow
);

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_e;

  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [XLEN-1:0] cnt_q  [4];
  logic [XLEN-1:0] cnt_d  [4];
  logic [XLEN-1:0] snap_q [4];
  logic [3:0]      ovf_q, ovf_d;
  logic [3:0]      inc;
  logic            accept;
  logic            capture;

  assign accept = req_valid & req_ready;

  // Index order {write, read, miss, hit} matches the overflow bit layout.
  assign inc = {accept & req_we, accept & ~req_we,
                resp_valid & ~resp_hit, resp_valid & resp_hit} & {4{count_en}};

  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (inc[i]) begin
        if (cnt_q[i] == '1) begin
          ovf_d[i] = 1'b1;
          cnt_d[i] = SATURATE ? '1 : '0;
        end else begin
          cnt_d[i] = cnt_q[i] + ONE;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (snap_req) begin
          capture = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!snap_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ovf_q   <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
        // Snapshot takes the pre-increment, pre-clear value of this cycle.
        if (capture) snap_q[i] <= cnt_q[i];
      end
    end
  end

  assign snap_ack    = (state_q == S_ACK);
  assign hit_value   = snap_q[0];
  assign miss_value  = snap_q[1];
  assign read_value  = snap_q[2];
  assign write_value = snap_q[3];
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_cache_perf_counter_unit.sv
// Directed bench for cache_perf_counter_unit: 32-bit saturating instance plus
// two 4-bit instances (saturating / wrapping) sharing the stimulus for overflow.
module tb_cache_perf_counter_unit;

  logic clk, reset_n, count_en, clear, req_valid, req_ready, req_we;
  logic resp_valid, resp_hit, snap_req;

  logic        ack;
  logic [31:0] hit_v, miss_v, read_v, write_v;
  logic [3:0]  ovf;

  logic        s_ack, w_ack;
  logic [3:0]  s_hit, s_miss, s_read, s_write, s_ovf;
  logic [3:0]  w_hit, w_miss, w_read, w_write, w_ovf;

  int total = 0;
  int bad   = 0;

  cache_perf_counter_unit #(.XLEN(32), .SATURATE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .count_en(count_en), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .snap_req(snap_req),
    .snap_ack(ack), .hit_value(hit_v), .miss_value(miss_v),
    .read_value(read_v), .write_value(write_v), .overflow(ovf)
  );

  cache_perf_counter_unit #(.XLEN(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset_n(reset_n), .count_en(count_en), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .snap_req(snap_req),
    .snap_ack(s_ack), .hit_value(s_hit), .miss_value(s_miss),
    .read_value(s_read), .write_value(s_write), .overflow(s_ovf)
  );

  cache_perf_counter_unit #(.XLEN(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .count_en(count_en), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .snap_req(snap_req),
    .snap_ack(w_ack), .hit_value(w_hit), .miss_value(w_miss),
    .read_value(w_read), .write_value(w_write), .overflow(w_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap(input string tag, input logic [31:0] eh, input logic [31:0] em,
                      input logic [31:0] er, input logic [31:0] ew);
    snap_req = 1'b1;
    tick();
    chk({tag, "_ack1"}, 32'(ack), 32'd1);
    chk({tag, "_hit"}, hit_v, eh);
    chk({tag, "_miss"}, miss_v, em);
    chk({tag, "_read"}, read_v, er);
    chk({tag, "_write"}, write_v, ew);
    snap_req = 1'b0;
    tick();
    chk({tag, "_ack0"}, 32'(ack), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; count_en = 1'b1; clear = 1'b0; req_valid = 1'b0;
    req_ready = 1'b0; req_we = 1'b0; resp_valid = 1'b0; resp_hit = 1'b0;
    snap_req = 1'b0;
    tick(2);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_hit", hit_v, 32'd0);
    chk("rst_write", write_v, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: 3 reads, 2 writes, 4 hits, 1 miss
    req_valid = 1'b1; req_ready = 1'b1; req_we = 1'b0;
    tick(3);
    req_we = 1'b1;
    tick(2);
    req_valid = 1'b0; req_we = 1'b0;
    resp_valid = 1'b1; resp_hit = 1'b1;
    tick(4);
    resp_hit = 1'b0;
    tick();
    resp_valid = 1'b0;
    snap("t1", 32'd4, 32'd1, 32'd3, 32'd2);
    chk("t1_ovf", 32'(ovf), 32'd0);

    // 2: clear, then stalled requests never count
    clear = 1'b1;
    tick();
    clear = 1'b0;
    req_valid = 1'b1; req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_we = i[0];
      tick();
    end
    req_valid = 1'b0; req_we = 1'b0;
    snap("t2", 32'd0, 32'd0, 32'd0, 32'd0);

    // 3: 16 hits overflow the 4-bit instances
    resp_valid = 1'b1; resp_hit = 1'b1;
    tick(16);
    resp_valid = 1'b0; resp_hit = 1'b0;
    snap("t3", 32'd16, 32'd0, 32'd0, 32'd0);
    chk("t3_ovf", 32'(ovf), 32'd0);
    chk("t3_sat_hit", 32'(s_hit), 32'hF);
    chk("t3_sat_ovf", 32'(s_ovf), 32'b0001);
    chk("t3_sat_miss", 32'(s_miss), 32'd0);
    chk("t3_wrap_hit", 32'(w_hit), 32'h0);
    chk("t3_wrap_ovf", 32'(w_ovf), 32'b0001);
    chk("t3_wrap_read", 32'(w_read), 32'd0);

    // 4: clear + hit + snap_req same cycle; held snap_req does not recapture
    clear = 1'b1; resp_valid = 1'b1; resp_hit = 1'b1; snap_req = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_ack", 32'(ack), 32'd1);
    chk("t4_hit_pre", hit_v, 32'd16);
    chk("t4_sat_hit_pre", 32'(s_hit), 32'hF);
    chk("t4_ovf_clr", 32'(ovf), 32'd0);
    chk("t4_sat_ovf_clr", 32'(s_ovf), 32'd0);
    tick();
    resp_valid = 1'b0; resp_hit = 1'b0;
    chk("t4_hold_hit", hit_v, 32'd16);
    chk("t4_hold_ack", 32'(ack), 32'd1);
    snap_req = 1'b0;
    tick();
    chk("t4_ack0", 32'(ack), 32'd0);
    snap("t4b", 32'd1, 32'd0, 32'd0, 32'd0);

    // 5: establish counts, then count_en=0 freezes them
    clear = 1'b1;
    tick();
    clear = 1'b0;
    req_valid = 1'b1; req_ready = 1'b1; req_we = 1'b0;
    resp_valid = 1'b1; resp_hit = 1'b1;
    tick();
    resp_hit = 1'b0;
    tick();
    req_valid = 1'b0; resp_valid = 1'b0;
    snap("t5a", 32'd1, 32'd1, 32'd2, 32'd0);
    count_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_ready = 1'b1; req_we = i[0];
      resp_valid = 1'b1; resp_hit = i[1];
      tick();
    end
    req_valid = 1'b0; resp_valid = 1'b0; req_we = 1'b0; resp_hit = 1'b0;
    count_en = 1'b1;
    snap("t5b", 32'd1, 32'd1, 32'd2, 32'd0);

    // 6: reset while in S_ACK, snap_req still high afterwards
    snap_req = 1'b1;
    tick();
    chk("t6_ack", 32'(ack), 32'd1);
    chk("t6_read", read_v, 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_ack", 32'(ack), 32'd0);
    chk("t6_rst_read", read_v, 32'd0);
    chk("t6_rst_hit", hit_v, 32'd0);
    chk("t6_rst_miss", miss_v, 32'd0);
    tick();
    reset_n = 1'b1;
    chk("t6_idle_ack", 32'(ack), 32'd0);
    tick();
    chk("t6_reack", 32'(ack), 32'd1);
    chk("t6_recap_read", read_v, 32'd0);
    chk("t6_recap_write", write_v, 32'd0);
    snap_req = 1'b0;
    tick();
    chk("t6_ack0", 32'(ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
